// File: rtl/button_event_decoder_pkg.sv
// Shared types and sizing helper for the button event decoder.
package button_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        LONG_HOLD
    } state_t;

    typedef struct packed {
        logic press;
        logic release_;
        logic short_;
        logic double_;
        logic long_;
        logic repeat_;
    } event_t;

    function automatic int unsigned cnt_width(input int unsigned long_c,
                                              input int unsigned gap_c,
                                              input int unsigned rep_c);
        int unsigned m;
        m = long_c;
        if (gap_c > m) m = gap_c;
        if (rep_c > m) m = rep_c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_event_decoder_edge.sv
// Registers the debounced level and derives its rising/falling edges against the registered copy.
module level_edge_detector (
    input  logic clk_i,
    input  logic a_rst_n_i,
    input  logic level_i,
    output logic level_q_o,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) level_q <= 1'b0;
        else            level_q <= level_i;
    end

    assign level_q_o = level_q;
    assign rise_o    = level_i & ~level_q;
    assign fall_o    = ~level_i & level_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/double/long event pulses.
// Optional auto-repeat while held after a long press: define BUTTON_EVENT_DECODER_REPEAT_EN.
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned GAP_CYCLES    = 12_500_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic clk_i,
    input  logic a_rst_n_i,
    input  logic level_i,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic double_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int unsigned CW = cnt_width(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES);
`endif

    logic          level_q;
    logic          rise;
    logic          fall;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          restart;
    event_t        ev_q, ev_d;

    level_edge_detector u_edge (
        .clk_i     (clk_i),
        .a_rst_n_i (a_rst_n_i),
        .level_i   (level_i),
        .level_q_o (level_q),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        restart     = 1'b0;
        ev_d        = '0;
        ev_d.press    = rise;
        ev_d.release_ = fall;

        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_d = GAP;
                end else if (level_i && cnt_q == LONG_LAST) begin
                    ev_d.long_ = 1'b1;
                    state_d    = LONG_HOLD;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = PRESS2;
                end else if (!level_i && cnt_q == GAP_LAST) begin
                    ev_d.short_ = 1'b1;
                    state_d     = IDLE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    ev_d.double_ = 1'b1;
                    state_d      = IDLE;
                end
            end
            LONG_HOLD: begin
                if (fall) begin
                    state_d = IDLE;
                end
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
                else if (level_i && cnt_q == REP_LAST) begin
                    ev_d.repeat_ = 1'b1;
                    restart      = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Every state entry (and each repeat) counts its triggering sample as the first one.
        cnt_d = (state_d != state_q || restart) ? CW'(1) : cnt_inc;
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
        end
    end

    assign pressed_o = level_q;
    assign press_o   = ev_q.press;
    assign release_o = ev_q.release_;
    assign short_o   = ev_q.short_;
    assign double_o  = ev_q.double_;
    assign long_o    = ev_q.long_;
    assign repeat_o  = ev_q.repeat_;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder (LONG=16, GAP=8, REPEAT=4).
module tb_button_event_decoder;

    localparam int P  = 32;
    localparam int R  = 16;
    localparam int S  = 8;
    localparam int D  = 4;
    localparam int L  = 2;
    localparam int RP = 1;

    typedef struct {
        int    cyc;
        int    vec;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic level;
    logic pressed_o, press_o, release_o, short_o, double_o, long_o, repeat_o;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rep_cnt = 0;
    int   t0;
    exp_t exp_q[$];

    button_event_decoder #(
        .LONG_CYCLES   (16),
        .GAP_CYCLES    (8),
        .REPEAT_CYCLES (4)
    ) dut (
        .clk_i     (clk),
        .a_rst_n_i (rst_n),
        .level_i   (level),
        .pressed_o (pressed_o),
        .press_o   (press_o),
        .release_o (release_o),
        .short_o   (short_o),
        .double_o  (double_o),
        .long_o    (long_o),
        .repeat_o  (repeat_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input int c, input int v, input string tag);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic val, input int n);
        level = val;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pressed"}, int'(pressed_o), 0);
        check_eq({tag, "_events"},
                 int'({press_o, release_o, short_o, double_o, long_o, repeat_o}), 0);
    endtask

    always @(negedge clk) begin
        int   vec;
        exp_t e;
        vec = int'({press_o, release_o, short_o, double_o, long_o, repeat_o});
        if (repeat_o) rep_cnt++;
        if (vec != 0) begin
            check_eq("one_hot_events",
                     int'($countones({short_o, double_o, long_o, repeat_o}) > 1), 0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_event", vec, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq({e.tag, "_cycle"}, cyc, e.cyc);
                check_eq({e.tag, "_vec"}, vec, e.vec);
            end
        end
    end

    initial begin
        level = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset_state");
        @(negedge clk) rst_n = 1'b1;
        hold(1'b0, 3);

        // 1: reset asserted mid-cycle while pressed
        t0 = cyc + 1;
        push(t0, P, "t1_press");
        hold(1'b1, 4);
        check_eq("t1_pressed_high", int'(pressed_o), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t1_async_reset");
        level = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        hold(1'b0, 20);
        check_eq("t1_no_pending", exp_q.size(), 0);
        t0 = cyc + 1;
        push(t0, P, "t1_repress");
        push(t0 + 2, R, "t1_rerelease");
        push(t0 + 9, S, "t1_reshort");
        hold(1'b1, 2);
        hold(1'b0, 20);
        check_eq("t1_qempty", exp_q.size(), 0);

        // 2: single click
        t0 = cyc + 1;
        push(t0, P, "t2_press");
        push(t0 + 5, R, "t2_release");
        push(t0 + 12, S, "t2_short");
        hold(1'b1, 5);
        hold(1'b0, 20);
        check_eq("t2_qempty", exp_q.size(), 0);
        check_eq("t2_pressed_low", int'(pressed_o), 0);

        // 3: double click
        t0 = cyc + 1;
        push(t0, P, "t3_press1");
        push(t0 + 5, R, "t3_release1");
        push(t0 + 8, P, "t3_press2");
        push(t0 + 12, R | D, "t3_double");
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 4);
        hold(1'b0, 20);
        check_eq("t3_qempty", exp_q.size(), 0);

        // 4/5: long press, with auto-repeat when enabled
        rep_cnt = 0;
        t0 = cyc + 1;
        push(t0, P, "t4_press");
        push(t0 + 15, L, "t4_long");
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
        push(t0 + 19, RP, "t5_repeat1");
        push(t0 + 23, RP, "t5_repeat2");
        push(t0 + 27, RP, "t5_repeat3");
`endif
        push(t0 + 30, R, "t4_release");
        hold(1'b1, 30);
        hold(1'b0, 20);
        check_eq("t4_qempty", exp_q.size(), 0);
`ifdef BUTTON_EVENT_DECODER_REPEAT_EN
        check_eq("t5_repeat_count", rep_cnt, 3);
`else
        check_eq("t5_repeat_count", rep_cnt, 0);
`endif

        // 6a: one sample short of the long threshold
        t0 = cyc + 1;
        push(t0, P, "t6_press");
        push(t0 + 15, R, "t6_release");
        push(t0 + 22, S, "t6_short");
        hold(1'b1, 15);
        hold(1'b0, 20);
        check_eq("t6_qempty", exp_q.size(), 0);

        // 6b: reset while waiting out the gap
        t0 = cyc + 1;
        push(t0, P, "t6r_press");
        push(t0 + 3, R, "t6r_release");
        hold(1'b1, 3);
        hold(1'b0, 3);
        rst_n = 1'b0;
        hold(1'b0, 2);
        rst_n = 1'b1;
        hold(1'b0, 20);
        check_eq("t6r_qempty", exp_q.size(), 0);
        check_eq("t6r_pressed_low", int'(pressed_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
